// File: rtl/axis_pkt_trailer.sv
// AXI-Stream trailer appender: forwards payload bytes, then appends
// {length[15:8], length[7:0], xor checksum} with TLAST moved to the checksum.
module axis_pkt_trailer #(
    parameter int DW = 8,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] s_data_in,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic [DW-1:0] m_data_out,
    output logic          m_valid,
    output logic          m_last,
    input  logic          m_ready,
    output logic [LW-1:0] pkt_count,
    output logic          busy
);

    // state    | meaning
    // PASS     | forwarding payload bytes, input open when output register free
    // T_LEN_HI | emit high byte of payload length
    // T_LEN_LO | emit low byte of payload length
    // T_CSUM   | emit xor checksum with m_last, then clear accumulators
    typedef enum logic [1:0] {
        PASS     = 2'd0,
        T_LEN_HI = 2'd1,
        T_LEN_LO = 2'd2,
        T_CSUM   = 2'd3
    } state_t;

    state_t        r_state;
    logic [LW-1:0] r_len;
    logic [DW-1:0] r_csum;

    logic w_free;
    logic w_in_hs;
    logic w_out_hs;

    assign w_free   = !m_valid || m_ready;
    assign s_ready  = reset && (r_state == PASS) && w_free;
    assign w_in_hs  = s_valid && s_ready;
    assign w_out_hs = m_valid && m_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= PASS;
            r_len      <= '0;
            r_csum     <= '0;
            m_data_out <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            pkt_count  <= '0;
            busy       <= 1'b0;
        end else begin
            if (w_out_hs && m_last) begin
                pkt_count <= pkt_count + LW'(1);
                busy      <= 1'b0;
            end
            // a new packet starting on the checksum's accept cycle keeps busy high
            if (w_in_hs) begin
                busy <= 1'b1;
            end

            case (r_state)
                PASS: begin
                    if (w_in_hs) begin
                        m_data_out <= s_data_in;
                        m_valid    <= 1'b1;
                        m_last     <= 1'b0;
                        r_len      <= r_len + LW'(1);
                        r_csum     <= r_csum ^ s_data_in;
                        if (s_last) begin
                            r_state <= T_LEN_HI;
                        end
                    end else if (w_free) begin
                        m_valid <= 1'b0;
                    end
                end
                T_LEN_HI: begin
                    if (w_free) begin
                        m_data_out <= r_len[15:8];
                        m_valid    <= 1'b1;
                        m_last     <= 1'b0;
                        r_state    <= T_LEN_LO;
                    end
                end
                T_LEN_LO: begin
                    if (w_free) begin
                        m_data_out <= r_len[7:0];
                        m_valid    <= 1'b1;
                        m_last     <= 1'b0;
                        r_state    <= T_CSUM;
                    end
                end
                T_CSUM: begin
                    if (w_free) begin
                        m_data_out <= r_csum;
                        m_valid    <= 1'b1;
                        m_last     <= 1'b1;
                        r_len      <= '0;
                        r_csum     <= '0;
                        r_state    <= PASS;
                    end
                end
                default: r_state <= PASS;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_trailer.sv
// Self-checking bench for axis_pkt_trailer: packets are framed by a byte-level
// reference model and the output stream is scored beat by beat.
module tb_axis_pkt_trailer;

    logic        clk;
    logic        reset;
    logic [7:0]  s_data_in;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  m_data_out;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic [15:0] pkt_count;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int exp_pkts = 0;

    logic [7:0] pkt_q[$];
    logic [7:0] src_q[$];
    logic       lst_q[$];
    logic [8:0] exp_q[$];

    axis_pkt_trailer #(.DW(8), .LW(16)) dut (
        .clk(clk), .reset(reset),
        .s_data_in(s_data_in), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data_out(m_data_out), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .pkt_count(pkt_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference framing: payload, then length mod 2^16 big-endian, then xor of payload.
    task automatic frame_pkt();
        int n;
        logic [7:0] x;
        logic [15:0] len;
        n = pkt_q.size();
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            src_q.push_back(pkt_q[i]);
            lst_q.push_back(i == n - 1);
            exp_q.push_back({1'b0, pkt_q[i]});
            x = x ^ pkt_q[i];
        end
        len = 16'(n % 65536);
        exp_q.push_back({1'b0, len[15:8]});
        exp_q.push_back({1'b0, len[7:0]});
        exp_q.push_back({1'b1, x});
        exp_pkts++;
        pkt_q.delete();
    endtask

    task automatic stream(input int rdy_pct, input int vld_pct, input int budget,
                          output int beats, output int cycles);
        int si;
        logic offering, held, hl;
        logic [7:0] hd;
        si = 0; beats = 0; cycles = 0; offering = 0; held = 0; hl = 0; hd = 0;
        while ((si < src_q.size() || exp_q.size() > 0) && cycles < budget) begin
            @(negedge clk);
            m_ready = ($urandom_range(99) < rdy_pct);
            if (si < src_q.size() && (offering || $urandom_range(99) < vld_pct)) begin
                s_valid = 1'b1; s_data_in = src_q[si]; s_last = lst_q[si];
            end else begin
                s_valid = 1'b0; s_data_in = 8'($urandom); s_last = 1'($urandom);
            end
            #1;
            if (held) begin
                checks++;
                if (!(m_valid === 1'b1 && m_data_out === hd && m_last === hl)) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                             m_valid, m_data_out, m_last, hd, hl);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got d=%h l=%b, need no beat", m_data_out, m_last);
                end else begin
                    if ({m_last, m_data_out} !== exp_q[0]) begin
                        errors++;
                        $display("FAIL beat%0d: got l=%b d=%h, need l=%b d=%h",
                                 beats, m_last, m_data_out, exp_q[0][8], exp_q[0][7:0]);
                    end
                    void'(exp_q.pop_front());
                end
                beats++;
            end
            held = m_valid && !m_ready;
            hd = m_data_out; hl = m_last;
            if (s_valid && s_ready) begin
                si++; offering = 0;
            end else begin
                offering = s_valid;
            end
            cycles++;
        end
        checks++;
        if (cycles >= budget) begin
            errors++;
            $display("FAIL stream_timeout: got %0d cycles, need < %0d", cycles, budget);
        end
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: got v=%b busy=%b, need 0 0", m_valid, busy);
        end
        src_q.delete(); lst_q.delete(); exp_q.delete();
    endtask

    task automatic check_pkts(input string name);
        checks++;
        if (pkt_count !== 16'(exp_pkts)) begin
            errors++;
            $display("FAIL %s pkt_count: got %0d, need %0d", name, pkt_count, exp_pkts);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data_in = 8'h00; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({m_valid, m_last, m_data_out, pkt_count, busy, s_ready} !== 28'h0) begin
            errors++;
            $display("FAIL reset_vals: got v=%b l=%b d=%h cnt=%h busy=%b rdy=%b, need all 0",
                     m_valid, m_last, m_data_out, pkt_count, busy, s_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, need 1", s_ready);
        end
        exp_pkts = 0;
    endtask

    task automatic test_four_byte();
        int b, c;
        pkt_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        frame_pkt();
        stream(100, 100, 100, b, c);
        checks++;
        if (b != 7 || c != 8) begin
            errors++;
            $display("FAIL four_rate: got %0d beats in %0d cycles, need 7 in 8", b, c);
        end
        check_pkts("four");
    endtask

    task automatic test_one_byte();
        logic [7:0] e[4];
        e = '{8'hA5, 8'h00, 8'h01, 8'hA5};
        @(negedge clk);
        m_ready = 1'b1; s_valid = 1'b1; s_data_in = 8'hA5; s_last = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL one_accept: got s_ready=%b, need 1", s_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
            #1;
            checks++;
            if (m_valid !== 1'b1 || m_data_out !== e[i] || m_last !== (i == 3)) begin
                errors++;
                $display("FAIL one_beat%0d: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                         i, m_valid, m_data_out, m_last, e[i], (i == 3));
            end
            checks++;
            if (s_ready !== (i == 3) || busy !== 1'b1) begin
                errors++;
                $display("FAIL one_ready%0d: got rdy=%b busy=%b, need rdy=%b busy=1",
                         i, s_ready, busy, (i == 3));
            end
        end
        exp_pkts++;
        @(negedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL one_idle: got v=%b busy=%b, need 0 0", m_valid, busy);
        end
        check_pkts("one");
    endtask

    task automatic test_stall_11();
        int b, c;
        for (int i = 1; i <= 11; i++) pkt_q.push_back(8'(i));
        frame_pkt();
        stream(50, 100, 500, b, c);
        checks++;
        if (b != 14) begin
            errors++;
            $display("FAIL stall_beats: got %0d, need 14", b);
        end
        check_pkts("stall");
    endtask

    task automatic test_back_to_back();
        int b, c;
        pkt_q = '{8'h01, 8'h02};
        frame_pkt();
        pkt_q = '{8'h03};
        frame_pkt();
        stream(100, 100, 100, b, c);
        checks++;
        if (b != 9 || c != 10) begin
            errors++;
            $display("FAIL b2b_rate: got %0d beats in %0d cycles, need 9 in 10", b, c);
        end
        check_pkts("b2b");
    endtask

    task automatic test_random();
        int b, c, total;
        total = 0;
        for (int p = 0; p < 6; p++) begin
            int n;
            n = $urandom_range(20, 1);
            for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
            total += n + 3;
            frame_pkt();
        end
        stream(60, 70, 3000, b, c);
        checks++;
        if (b != total) begin
            errors++;
            $display("FAIL rand_beats: got %0d, need %0d", b, total);
        end
        check_pkts("rand");
    endtask

    task automatic test_reset_mid();
        int b, c;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m_ready = 1'b1; s_valid = 1'b1; s_data_in = 8'(i + 1); s_last = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_last, m_data_out, pkt_count, busy, s_ready} !== 28'h0) begin
            errors++;
            $display("FAIL midreset_vals: got v=%b l=%b d=%h cnt=%h busy=%b rdy=%b, need all 0",
                     m_valid, m_last, m_data_out, pkt_count, busy, s_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_pkts = 0;
        pkt_q = '{8'h07};
        frame_pkt();
        stream(100, 100, 100, b, c);
        checks++;
        if (b != 4) begin
            errors++;
            $display("FAIL midreset_beats: got %0d, need 4", b);
        end
        check_pkts("midreset");
    endtask

    task automatic test_wrap();
        int b, c;
        for (int i = 0; i < 70000; i++) pkt_q.push_back(8'h00);
        frame_pkt();
        stream(100, 100, 80000, b, c);
        checks++;
        if (b != 70003) begin
            errors++;
            $display("FAIL wrap_beats: got %0d, need 70003", b);
        end
        check_pkts("wrap");
    endtask

    initial begin
        test_reset();
        test_four_byte();
        test_one_byte();
        test_stall_11();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_pkt_trailer.md
# axis_pkt_trailer

AXI-Stream packet trailer appender placed directly downstream of the AXIS FIFO top (`final_top`). Its `s_*` port connects to the FIFO's `m_*` output. It passes each payload byte through unchanged, then appends a 3-byte trailer to the packet: payload length high byte, length low byte, and an XOR checksum. `m_last` moves from the last payload byte to the last trailer byte.

## Interface
- `DW`, 8: data width. Fixed at 8; the trailer is byte-oriented.
- `LW`, 16: width of the length counter and of `pkt_count`.

Ports:
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `s_data_in` in DW: payload byte from the FIFO.
- `s_valid` in 1: input beat valid.
- `s_last` in 1: input beat is the last byte of the packet.
- `s_ready` out 1: block accepts the input beat this cycle.
- `m_data_out` out DW: output byte.
- `m_valid` out 1: output beat valid.
- `m_last` out 1: output beat is the last byte of the framed packet (last trailer byte).
- `m_ready` in 1: downstream accepts the output beat.
- `pkt_count` out LW: number of completed framed packets. Wraps modulo 2^LW.
- `busy` out 1: high from the first accepted payload byte until the checksum beat is accepted downstream.

## Operation
- Single output register: `m_data_out`, `m_valid`, `m_last`. The register is "free" when `!m_valid || m_ready`.
- FSM states: PASS, T_LEN_HI, T_LEN_LO, T_CSUM.
- `s_ready = reset && state==PASS && free`. This is a combinational path from `m_ready`.
- PASS:
  - On input handshake (`s_valid && s_ready`): load `s_data_in` into the output register with `m_last=0`.
  - Update `len <= len+1` (wraps modulo 2^LW) and `csum <= csum ^ s_data_in`.
  - If `s_last`: go to T_LEN_HI, capturing the updated `len` and `csum` values.
- T_LEN_HI: when free, load `len[15:8]` with `m_last=0`; go to T_LEN_LO.
- T_LEN_LO: when free, load `len[7:0]` with `m_last=0`; go to T_CSUM.
- T_CSUM: when free, load `csum` with `m_last=1`; go to PASS; clear `len` and `csum`.
- `pkt_count` increments when the output handshake carries `m_last=1`.
- When free and there is no new load, the output register drops `m_valid` to 0.
- `s_last` on the very first byte is legal: a 1-byte packet, `len`=1.
- An empty packet cannot occur. A trailer is only triggered by an accepted beat.

## Timing
- Reset (`reset`=0, asynchronous) drives the following values:
  - State: PASS. `len`=0, `csum`=0.
  - `m_valid`=0, `m_data_out`=0, `m_last`=0.
  - `pkt_count`=0, `busy`=0.
  - `s_ready`=0 while `reset`=0.
- A reset asserted mid-packet discards the partial packet and any pending trailer. No trailer is emitted afterwards.
- Latency: an input byte accepted at edge k is presented on `m_data_out` after edge k, i.e. visible in cycle k+1.
- Throughput:
  - 1 byte/cycle within a packet while `m_ready`=1.
  - 3-cycle input bubble per packet while the trailer drains.
  - An N-byte packet yields N+3 output beats.
- Handshake rules:
  - While `m_valid`=1 and `m_ready`=0, `m_data_out` and `m_last` stay stable.
  - `s_ready` stays 0 under the same condition, so no byte is dropped or duplicated.
- Simultaneous output accept and new input load in the same cycle is allowed and sustains full rate.
- Length arithmetic: `len` wraps modulo 2^LW. A 70000-byte packet reports 70000-65536 = 4464 = 0x1170.

## Test plan
- 4-byte packet 0x10,0x20,0x30,0x40 (last on 0x40), `m_ready`=1 -> output 0x10,0x20,0x30,0x40,0x00,0x04,0x40; `m_last` only on the final 0x40; `pkt_count`=1; 7 output beats in 7 consecutive cycles.
- 1-byte packet 0xA5 with `s_last`=1 -> output 0xA5,0x00,0x01,0xA5 (last); `s_ready`=0 for the 3 trailer cycles.
- 11-byte packet 0x01..0x0B with `m_ready` toggled pseudo-randomly (≈50%) -> 14 beats; trailer 0x00,0x0B,0x00; every beat held stable while stalled; no loss or duplication against a scoreboard.
- Back-to-back packets [0x01,0x02] and [0x03]:
  - First packet -> 0x01,0x02,0x00,0x02,0x03(last).
  - Second packet -> 0x03,0x00,0x01,0x03(last).
  - `len`/`csum` cleared between packets; `pkt_count`=2.
- Assert `reset`=0 after 3 bytes of a 5-byte packet:
  - All outputs at reset values immediately (asynchronous).
  - After release, packet 0x07 (last) -> 0x07,0x00,0x01,0x07; `pkt_count`=1.
- 70000-byte packet of 0x00 -> trailer 0x11,0x70,0x00.
